// File: rtl/pre_if_stage.sv
// Pre-IF stage: selects the next fetch PC (sequential / branch / exception),
// drives the address phase of the instruction SRAM-like bus and hands each
// accepted fetch PC to IF.
//
// Handshakes: to_fs_valid/fs_allowin transfer an entry in any cycle where
// both are high. inst_sram_req/inst_sram_addr_ok complete a request in any
// cycle where both are high. Once req is raised it stays high, with a stable
// address, until addr_ok.
module pre_if_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_target,
    input  logic        ws_handle_ex,
    input  logic [31:0] ex_pc,
    input  logic        fs_allowin,
    output logic        to_fs_valid,
    output logic [32:0] to_fs_bus,
    output logic        drop_resp,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2} state_t;
    typedef enum logic [1:0] {SRC_NPC = 2'd0, SRC_BR = 2'd1, SRC_EX = 2'd2} src_t;

    state_t      r_state;
    src_t        r_req_src;
    logic [31:0] r_req_addr;
    logic [31:0] r_npc;
    logic [31:0] r_last_pc;
    logic        r_br_buf_valid;
    logic        r_br_buf_wait_ds;
    logic [31:0] r_br_buf_target;
    logic [31:0] r_br_ds_pc;
    logic        r_ex_buf_valid;
    logic [31:0] r_ex_buf_pc;
    logic        r_cancel;
    logic [32:0] r_hold_bus;

    logic [31:0] w_sel_addr;
    src_t        w_sel_src;
    logic [31:0] w_cur_addr;
    src_t        w_cur_src;
    logic        w_br_hit;
    logic        w_idle_go;
    logic        w_idle_req;
    logic        w_idle_adel;
    logic        w_req;
    logic        w_hs;
    logic        w_stale;
    logic        w_hs_good;
    logic        w_hold_out;
    logic        w_consume;

    // Fetch-address selection and handshake qualification.
    always_comb begin
        w_sel_addr = r_npc;
        w_sel_src  = SRC_NPC;
        if (r_ex_buf_valid) begin
            w_sel_addr = r_ex_buf_pc;
            w_sel_src  = SRC_EX;
        end else if (r_br_buf_valid && !r_br_buf_wait_ds) begin
            w_sel_addr = r_br_buf_target;
            w_sel_src  = SRC_BR;
        end
        w_br_hit   = br_valid && br_taken;
        // A redirect pulse in IDLE defers issue by one cycle so the new
        // buffer contents steer the very next fetch.
        w_idle_go   = (r_state == S_IDLE) && resetn && fs_allowin && !ws_handle_ex && !w_br_hit;
        w_idle_req  = w_idle_go && (w_sel_addr[1:0] == 2'b00);
        w_idle_adel = w_idle_go && (w_sel_addr[1:0] != 2'b00);
        w_cur_addr  = (r_state == S_REQ) ? r_req_addr : w_sel_addr;
        w_cur_src   = (r_state == S_REQ) ? r_req_src : w_sel_src;
        w_req       = w_idle_req || (r_state == S_REQ);
        w_hs        = w_req && inst_sram_addr_ok;
        w_stale     = (r_state == S_REQ) && (r_cancel || ws_handle_ex);
        w_hs_good   = w_hs && !w_stale;
        w_hold_out  = (r_state == S_HOLD) && !ws_handle_ex;
        w_consume   = w_hs_good || w_idle_adel;
    end

    // Output drive: entries go to IF combinationally on a good handshake.
    always_comb begin
        inst_sram_req   = w_req;
        inst_sram_addr  = w_req ? w_cur_addr : 32'd0;
        inst_sram_wr    = 1'b0;
        inst_sram_size  = 2'd2;
        inst_sram_wdata = 32'd0;
        to_fs_valid     = w_hs_good || w_idle_adel || w_hold_out;
        to_fs_bus       = 33'd0;
        if (w_hold_out)
            to_fs_bus = r_hold_bus;
        else if (w_hs_good || w_idle_adel)
            to_fs_bus = {w_idle_adel, w_cur_addr};
        drop_resp   = (w_hs && w_stale) || ((r_state == S_HOLD) && ws_handle_ex);
        o_dbg_state = r_state;
    end

    // PC bookkeeping, redirect buffers and the request FSM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state          <= S_IDLE;
            r_req_src        <= SRC_NPC;
            r_req_addr       <= 32'd0;
            r_npc            <= RESET_PC;
            r_last_pc        <= RESET_PC - 32'd4;
            r_br_buf_valid   <= 1'b0;
            r_br_buf_wait_ds <= 1'b0;
            r_br_buf_target  <= 32'd0;
            r_br_ds_pc       <= 32'd0;
            r_ex_buf_valid   <= 1'b0;
            r_ex_buf_pc      <= 32'd0;
            r_cancel         <= 1'b0;
            r_hold_bus       <= 33'd0;
        end else begin
            if (w_consume) begin
                r_last_pc <= w_cur_addr;
                r_npc     <= w_cur_addr + 32'd4;
                if (w_cur_src == SRC_EX) begin
                    r_ex_buf_valid   <= 1'b0;
                    r_br_buf_valid   <= 1'b0;
                    r_br_buf_wait_ds <= 1'b0;
                end else if (w_cur_src == SRC_BR) begin
                    r_br_buf_valid <= 1'b0;
                end
                if (r_br_buf_valid && r_br_buf_wait_ds && (w_cur_addr == r_br_ds_pc))
                    r_br_buf_wait_ds <= 1'b0;
            end

            // A new branch overrides whatever consumption did above.
            if (w_br_hit && !ws_handle_ex) begin
                r_br_buf_valid   <= 1'b1;
                r_br_buf_target  <= br_target;
                r_br_ds_pc       <= br_pc + 32'd4;
                r_br_buf_wait_ds <= (r_last_pc == br_pc) &&
                                    !(w_consume && (w_cur_addr == br_pc + 32'd4));
            end

            // Exceptions win over everything else in the same cycle.
            if (ws_handle_ex) begin
                r_ex_buf_valid   <= 1'b1;
                r_ex_buf_pc      <= ex_pc;
                r_br_buf_valid   <= 1'b0;
                r_br_buf_wait_ds <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_idle_req && !inst_sram_addr_ok) begin
                        r_state    <= S_REQ;
                        r_req_addr <= w_sel_addr;
                        r_req_src  <= w_sel_src;
                    end
                end
                S_REQ: begin
                    if (inst_sram_addr_ok) begin
                        if (w_stale) begin
                            r_state  <= S_IDLE;
                            r_cancel <= 1'b0;
                        end else if (fs_allowin) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state    <= S_HOLD;
                            r_hold_bus <= {1'b0, r_req_addr};
                        end
                    end else begin
                        if (ws_handle_ex)
                            r_cancel <= 1'b1;
                        // A branch buffered mid-request must survive this
                        // request's consumption.
                        if (w_br_hit)
                            r_req_src <= SRC_NPC;
                    end
                end
                S_HOLD: begin
                    if (ws_handle_ex || fs_allowin)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pre_if_stage.sv
// Bench for pre_if_stage: directed scenarios followed by a randomized
// stall/exception run checked against a fetch-stream model.
module tb_pre_if_stage;

    logic        clk;
    logic        resetn;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [31:0] br_target;
    logic        ws_handle_ex;
    logic [31:0] ex_pc;
    logic        fs_allowin;
    logic        to_fs_valid;
    logic [32:0] to_fs_bus;
    logic        drop_resp;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic [1:0]  dbg_state;

    int checks;
    int errors;

    pre_if_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .br_valid          (br_valid),
        .br_taken          (br_taken),
        .br_pc             (br_pc),
        .br_target         (br_target),
        .ws_handle_ex      (ws_handle_ex),
        .ex_pc             (ex_pc),
        .fs_allowin        (fs_allowin),
        .to_fs_valid       (to_fs_valid),
        .to_fs_bus         (to_fs_bus),
        .drop_resp         (drop_resp),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .o_dbg_state       (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        br_valid     = 1'b0;
        br_taken     = 1'b0;
        ws_handle_ex = 1'b0;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_in(input logic alw, input logic aok);
        fs_allowin        = alw;
        inst_sram_addr_ok = aok;
    endtask

    // Expect a request for addr handshaken and its entry offered this cycle.
    task automatic chk_fetch(input string tag, input logic [31:0] addr);
        chk({tag, "_req"}, {63'd0, inst_sram_req}, 64'd1);
        chk({tag, "_addr"}, {32'd0, inst_sram_addr}, {32'd0, addr});
        chk({tag, "_valid"}, {63'd0, to_fs_valid}, 64'd1);
        chk({tag, "_bus"}, {31'd0, to_fs_bus}, {31'd0, 1'b0, addr});
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req"}, {63'd0, inst_sram_req}, 64'd0);
        chk({tag, "_addr"}, {32'd0, inst_sram_addr}, 64'd0);
        chk({tag, "_valid"}, {63'd0, to_fs_valid}, 64'd0);
        chk({tag, "_bus"}, {31'd0, to_fs_bus}, 64'd0);
        chk({tag, "_drop"}, {63'd0, drop_resp}, 64'd0);
        chk({tag, "_size"}, {62'd0, inst_sram_size}, 64'd2);
        chk({tag, "_wr"}, {63'd0, inst_sram_wr}, 64'd0);
        chk({tag, "_wdata"}, {32'd0, inst_sram_wdata}, 64'd0);
    endtask

    task automatic pulse_ex(input logic [31:0] pc);
        ws_handle_ex = 1'b1;
        ex_pc        = pc;
    endtask

    task automatic pulse_br(input logic [31:0] pc, input logic [31:0] tgt);
        br_valid  = 1'b1;
        br_taken  = 1'b1;
        br_pc     = pc;
        br_target = tgt;
    endtask

    // Random-run model state: the PC the next IF transfer must carry.
    logic [31:0] model_next;
    logic        prev_wait;
    logic [31:0] prev_addr;
    int          xfers;

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        br_valid = 1'b0;
        br_taken = 1'b0;
        br_pc = 32'd0;
        br_target = 32'd0;
        ws_handle_ex = 1'b0;
        ex_pc = 32'd0;
        set_in(1'b0, 1'b0);

        // Reset state, including with fs_allowin high during reset.
        smp();
        chk_idle_outputs("reset");
        fs_allowin = 1'b1;
        #1;
        chk("reset_allowin_req", {63'd0, inst_sram_req}, 64'd0);
        tick();

        // Sequential fetch, one handshake per cycle.
        resetn = 1'b1;
        set_in(1'b1, 1'b1);
        smp(); chk_fetch("seq0", 32'hbfc00000); tick();
        smp(); chk_fetch("seq1", 32'hbfc00004); tick();
        smp(); chk_fetch("seq2", 32'hbfc00008); tick();

        // Branch resolved while its delay slot is still unissued.
        set_in(1'b1, 1'b0); pulse_ex(32'hbfc00000);
        smp(); chk("ex_idle_noreq", {63'd0, inst_sram_req}, 64'd0); tick();
        set_in(1'b1, 1'b1);
        smp(); chk_fetch("br1_a", 32'hbfc00000); tick();
        smp(); chk_fetch("br1_b", 32'hbfc00004); tick();
        set_in(1'b1, 1'b0); pulse_br(32'hbfc00004, 32'hbfc00100);
        smp(); tick();
        set_in(1'b1, 1'b1);
        smp(); chk_fetch("br1_ds", 32'hbfc00008); tick();
        smp(); chk_fetch("br1_tgt", 32'hbfc00100); tick();

        // Branch resolved after its delay slot has been issued.
        pulse_ex(32'hbfc00000);
        smp(); tick();
        smp(); chk_fetch("br2_a", 32'hbfc00000); tick();
        smp(); chk_fetch("br2_b", 32'hbfc00004); tick();
        smp(); chk_fetch("br2_c", 32'hbfc00008); tick();
        pulse_br(32'hbfc00004, 32'hbfc00100);
        smp(); tick();
        smp(); chk_fetch("br2_tgt", 32'hbfc00100); tick();

        // Exception while a request waits for addr_ok.
        set_in(1'b1, 1'b0);
        smp(); chk("exq_req0", {32'd0, inst_sram_addr}, 64'hbfc00104); tick();
        pulse_ex(32'hbfc00380);
        smp();
        chk("exq_req1", {63'd0, inst_sram_req}, 64'd1);
        chk("exq_addr1", {32'd0, inst_sram_addr}, 64'hbfc00104);
        chk("exq_valid1", {63'd0, to_fs_valid}, 64'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            smp();
            chk("exq_hold_req", {63'd0, inst_sram_req}, 64'd1);
            chk("exq_hold_addr", {32'd0, inst_sram_addr}, 64'hbfc00104);
            chk("exq_hold_drop", {63'd0, drop_resp}, 64'd0);
            tick();
        end
        set_in(1'b1, 1'b1);
        smp();
        chk("exq_stale_req", {63'd0, inst_sram_req}, 64'd1);
        chk("exq_stale_drop", {63'd0, drop_resp}, 64'd1);
        chk("exq_stale_valid", {63'd0, to_fs_valid}, 64'd0);
        tick();
        smp();
        chk("exq_after_drop", {63'd0, drop_resp}, 64'd0);
        chk_fetch("exq_new", 32'hbfc00380);
        tick();

        // Misaligned branch target: no request, address error entry.
        pulse_br(32'hbfc00000, 32'hbfc00102);
        smp(); tick();
        smp();
        chk("adel_req", {63'd0, inst_sram_req}, 64'd0);
        chk("adel_valid", {63'd0, to_fs_valid}, 64'd1);
        chk("adel_bus", {31'd0, to_fs_bus}, {31'd0, 1'b1, 32'hbfc00102});
        tick();
        pulse_ex(32'hbfc00000);
        smp();
        chk("adel_ex_valid", {63'd0, to_fs_valid}, 64'd0);
        tick();

        // IF stalls at the handshake: entry held, no new request.
        set_in(1'b1, 1'b0);
        smp(); chk("hold_req0", {32'd0, inst_sram_addr}, 64'hbfc00000); tick();
        set_in(1'b0, 1'b1);
        smp(); chk_fetch("hold_hs", 32'hbfc00000); tick();
        for (int i = 0; i < 2; i++) begin
            smp();
            chk("hold_noreq", {63'd0, inst_sram_req}, 64'd0);
            chk("hold_valid", {63'd0, to_fs_valid}, 64'd1);
            chk("hold_bus", {31'd0, to_fs_bus}, {31'd0, 1'b0, 32'hbfc00000});
            tick();
        end
        fs_allowin = 1'b1;
        smp();
        chk("hold_xfer_valid", {63'd0, to_fs_valid}, 64'd1);
        chk("hold_xfer_noreq", {63'd0, inst_sram_req}, 64'd0);
        tick();
        smp(); chk_fetch("hold_next", 32'hbfc00004); tick();

        // Exception discards a held entry.
        set_in(1'b1, 1'b0);
        smp(); tick();
        set_in(1'b0, 1'b1);
        smp(); chk_fetch("hx_hs", 32'hbfc00008); tick();
        pulse_ex(32'hbfc00200);
        smp();
        chk("hx_drop", {63'd0, drop_resp}, 64'd1);
        chk("hx_valid", {63'd0, to_fs_valid}, 64'd0);
        tick();
        set_in(1'b1, 1'b1);
        smp(); chk_fetch("hx_new", 32'hbfc00200); tick();

        // Asynchronous reset in the middle of a request.
        set_in(1'b1, 1'b0);
        smp(); chk("rst_req", {63'd0, inst_sram_req}, 64'd1); tick();
        #2;
        resetn = 1'b0;
        #1;
        chk_idle_outputs("rst_async");
        tick();
        resetn = 1'b1;
        set_in(1'b1, 1'b1);
        smp(); chk_fetch("rst_restart0", 32'hbfc00000); tick();
        smp(); chk_fetch("rst_restart1", 32'hbfc00004); tick();

        // Randomized stalls and exceptions against the fetch-stream model.
        model_next = 32'hbfc00008;
        prev_wait  = 1'b0;
        prev_addr  = 32'd0;
        xfers      = 0;
        for (int c = 0; c < 600; c++) begin
            fs_allowin        = ($urandom_range(0, 3) != 0);
            inst_sram_addr_ok = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0)
                pulse_ex(32'hbfc00000 + ({22'd0, 10'($urandom_range(0, 255))} << 2));
            smp();
            if (prev_wait) begin
                chk("rnd_req_stable", {63'd0, inst_sram_req}, 64'd1);
                chk("rnd_addr_stable", {32'd0, inst_sram_addr}, {32'd0, prev_addr});
            end
            if (ws_handle_ex)
                chk("rnd_ex_nooffer", {63'd0, to_fs_valid}, 64'd0);
            if (to_fs_valid && fs_allowin) begin
                chk("rnd_xfer_pc", {31'd0, to_fs_bus}, {31'd0, 1'b0, model_next});
                model_next = model_next + 32'd4;
                xfers++;
            end
            prev_wait = inst_sram_req && !inst_sram_addr_ok;
            prev_addr = inst_sram_addr;
            if (ws_handle_ex)
                model_next = ex_pc;
            tick();
        end
        chk("rnd_progress", {63'd0, (xfers > 100)}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
